// File: rtl/addsub_arbiter_pkg.sv
// Shared widths, opcodes, FSM encodings and the signed-overflow helper for the add/sub arbiter.
`timescale 1ns/1ps
package addsub_arbiter_pkg;

  localparam int   ADDSUB_W = 4;
  localparam logic OP_ADD   = 1'b0;
  localparam logic OP_SUB   = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDSUB_W-1:0] a;
    logic [ADDSUB_W-1:0] b;
    logic                mode;
  } op_t;

  // Effective second operand is b for add and ~b for sub, so overflow compares a against b^mode.
  function automatic logic signed_ovf(input op_t op, input logic [ADDSUB_W-1:0] res);
    return (op.a[ADDSUB_W-1] == (op.b[ADDSUB_W-1] ^ op.mode)) &&
           (res[ADDSUB_W-1] != op.a[ADDSUB_W-1]);
  endfunction

endpackage

// File: rtl/addsub.sv
// Shared 4-bit adder/subtractor, result modulo 2^ADDSUB_W.
// Latency: combinational.
// Backpressure: none, pure datapath.
`timescale 1ns/1ps
module addsub
  import addsub_arbiter_pkg::*;
(
  output logic [ADDSUB_W-1:0] result,
  input  logic [ADDSUB_W-1:0] operand_a,
  input  logic [ADDSUB_W-1:0] operand_b,
  input  logic                mode
);

  logic sub;

  // Subtraction as a + ~b + 1: the mode bit doubles as the carry-in.
  assign sub    = (mode == OP_SUB);
  assign result = operand_a + (operand_b ^ {ADDSUB_W{sub}}) + {{(ADDSUB_W-1){1'b0}}, sub};

endmodule

// File: rtl/addsub_arbiter.sv
// Arbitrates two requesters onto one addsub unit and buffers one result with overflow flag.
// Latency: one cycle from accept to resp_valid; one op per cycle when resp_ready stays high.
// Backpressure: a full buffer with resp_ready low deasserts both req ready outputs.
`timescale 1ns/1ps
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic [ADDSUB_W-1:0] req0_a,
  input  logic [ADDSUB_W-1:0] req0_b,
  input  logic                req0_mode,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [ADDSUB_W-1:0] req1_a,
  input  logic [ADDSUB_W-1:0] req1_b,
  input  logic                req1_mode,
  output logic                req1_ready,
  output logic                resp_valid,
  output logic [ADDSUB_W-1:0] resp_data,
  output logic                resp_id,
  output logic                resp_ovf,
  input  logic                resp_ready
);

  state_t              state;
  logic                last;
  logic                grant;
  logic                any_valid;
  logic                can_accept;
  logic                accept;
  op_t                 op;
  logic [ADDSUB_W-1:0] sum;

  assign any_valid = req0_valid | req1_valid;
  // Port 1 wins alone, or on a tie under round-robin when port 0 went last.
  assign grant     = req1_valid & (~req0_valid | (RR & ~last));

  // Gated by reset so no handshake completes while the block is held in reset.
  assign can_accept = ~reset & ((state == ST_EMPTY) | ((state == ST_FULL) & resp_ready));
  assign accept     = can_accept & any_valid;
  assign req0_ready = accept & ~grant;
  assign req1_ready = accept & grant;

  always_comb begin
    op = '0;
    if (grant) op = '{a: req1_a, b: req1_b, mode: req1_mode};
    else       op = '{a: req0_a, b: req0_b, mode: req0_mode};
  end

  addsub u_addsub (
    .result    (sum),
    .operand_a (op.a),
    .operand_b (op.b),
    .mode      (op.mode)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_EMPTY;
      last       <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
      resp_ovf   <= 1'b0;
    end else begin
      if (accept) begin
        last       <= grant;
        resp_valid <= 1'b1;
        resp_data  <= sum;
        resp_id    <= grant;
        resp_ovf   <= signed_ovf(op, sum);
      end
      case (state)
        ST_EMPTY: if (accept) state <= ST_FULL;
        ST_FULL: begin
          // Draining with nothing to refill keeps the stale payload, only valid drops.
          if (resp_ready && !accept) begin
            state      <= ST_EMPTY;
            resp_valid <= 1'b0;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one 4-bit `addsub` unit between two requesters (port 0, port 1) using valid/ready handshakes.
- Arbitrates round-robin (or fixed priority), drives the shared unit combinationally and registers the result into a one-entry response buffer with backpressure.
- Adds the signed-overflow flag, which the shared unit does not produce.
- Sits between requesting sequencers and the shared `addsub` datapath.

Parameters:
- RR, 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- req0_valid  input  1  port 0 has an operation pending
- req0_a  input  4  port 0 operand_a
- req0_b  input  4  port 0 operand_b
- req0_mode  input  1  port 0 op: 0 = a+b, 1 = a-b
- req0_ready  output  1  port 0 operation accepted this cycle
- req1_valid, req1_a, req1_b, req1_mode, req1_ready  same as port 0, for port 1
- resp_valid  output  1  response buffer holds a result
- resp_data  output  4  result, modulo 16
- resp_id  output  1  port that issued the result
- resp_ovf  output  1  two's-complement overflow of the operation
- resp_ready  input  1  consumer takes the response this cycle

Behaviour:
- Reset (asynchronous, active-high):
  - resp_valid=0, resp_data=0, resp_id=0, resp_ovf=0.
  - Round-robin pointer last=1, so port 0 has priority first.
  - FSM goes to EMPTY.
- FSM states: EMPTY (buffer empty), FULL (buffer holds an unconsumed result).
- can_accept = (state==EMPTY) | (state==FULL & resp_ready).
- Grant (combinational):
  - Only one valid: that port wins.
  - Both valid with RR=1: the port != last wins.
  - Both valid with RR=0: port 0 wins.
  - reqN_ready = can_accept & grant==N. At most one ready per cycle; never ready when nothing is valid.
- Datapath:
  - The shared unit is fed through a mux from the granted port: operand_a, operand_b, mode.
  - Subtraction is a + ~b + 1, i.e. the mode bit feeds the carry-in.
  - ovf = (a[3] == (b[3]^mode)) & (result[3] != a[3]).
- Accept (handshake valid & ready) at edge T:
  - At T+1: resp_valid=1, resp_data, resp_id=grant, resp_ovf all loaded; state FULL. Latency is one cycle.
  - last <= grant, updated only on accept.
- Transitions:
  - EMPTY, no accept: stay EMPTY.
  - EMPTY, accept: go to FULL.
  - FULL, resp_ready=0: hold; resp_* stable; both ready outputs 0.
  - FULL, resp_ready=1 with accept: stay FULL, load the new result. Back-to-back throughput is one operation per cycle.
  - FULL, resp_ready=1 without accept: go to EMPTY, resp_valid=0. resp_data/id/ovf keep their last values.
- resp_ready while EMPTY is ignored.
- Requesters must hold operands stable while valid and not ready. The arbiter does not latch inputs before accept.
- Wrap-around: results are modulo 16.
  - 15+1 gives 0, ovf=0.
  - 7+1 gives 8, ovf=1.
  - 0-1 gives 15, ovf=0.
  - 8-1 gives 7, ovf=1.
- Reset asserted mid-operation: a pending result is discarded, no ready is issued, and port 0 has priority again after release.

Decomposition:
- Shared constants header, included by this block:
  - Width `ADDSUB_W`=4.
  - Opcodes `OP_ADD`=0, `OP_SUB`=1.
  - FSM state encodings `ST_EMPTY`=0, `ST_FULL`=1.
- Sub-module: exactly one instance of the existing `addsub` (ports result, operand_a, operand_b, mode). No duplicate adder.
- Arbitration is plain combinational logic inside this block; no separate arbiter module.

Test Plan:
- Reset, then port 0 only: a=3, b=4, mode=0 -> req0_ready=1 same cycle; next cycle resp_valid=1, data=7, id=0, ovf=0.
- Port 1 only: a=2, b=5, mode=1 -> data=13 (−3), id=1, ovf=0. Then a=8, b=1, mode=1 -> data=7, ovf=1.
- Both ports continuously valid, resp_ready=1, RR=1:
  - Grants alternate 0,1,0,1 on consecutive cycles, one response per cycle.
  - With RR=0: all grants go to port 0.
- Backpressure: accept, then hold resp_ready=0 for 3 cycles -> both ready=0 and resp_* stable. Raise resp_ready with req1 valid -> drain and accept the same cycle, new result next cycle.
- Wrap and overflow:
  - 15+1 -> 0, ovf=0.
  - 7+1 -> 8, ovf=1.
  - 0-1 -> 15, ovf=0.
- Reset asserted asynchronously while FULL -> resp_valid drops immediately without a clock edge. After release, both valid -> port 0 granted first.
